// File: rtl/code_lock_fsm.sv
// code_lock_fsm: keypad code-lock controller.
//   Collects CODE_LEN digits, compares them with a stored code, and reports
//   open / wrong-code through Moore outputs. It counts consecutive failures
//   and sounds a timed buzzer lockout after MAX_FAIL of them. The stored code
//   can be replaced while open and reverts to DEFAULT_CODE on reset.
//   Optional build macro ENTRY_TIMEOUT_EN: when defined, an attempt that sits
//   in ENTRY for TIMEOUT_CYCLES cycles without a digit counts as a failure.
//
// Ports:
//   clock       in   system clock, rising edge
//   clear_n     in   asynchronous active-low reset
//   digit_valid in   one-cycle strobe qualifying digit
//   digit       in   entered digit value (DIGIT_W)
//   relock      in   return from OPEN to IDLE
//   code_load   in   store code_in as the new code (OPEN only)
//   code_in     in   new code, digit 0 in MSBs (CODE_LEN*DIGIT_W)
//   led_right   out  high while OPEN
//   led_wrong   out  high while ERROR
//   buzzer      out  high while LOCKOUT
//   fail_count  out  consecutive failed attempts, saturating at MAX_FAIL
module code_lock_fsm #(
    parameter int unsigned DIGIT_W        = 2,
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 8'b00110011,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned CODE_W = CODE_LEN * DIGIT_W,
    localparam int unsigned FC_W   = $clog2(MAX_FAIL + 1)
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               relock,
    input  logic               code_load,
    input  logic [CODE_W-1:0]  code_in,
    output logic               led_right,
    output logic               led_wrong,
    output logic               buzzer,
    output logic [FC_W-1:0]    fail_count
);

    localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned LT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FAIL_MAX  = FC_W'(MAX_FAIL);
    localparam logic [LT_W-1:0]  LOCK_LOAD = LT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_OPEN,
        ST_ERROR,
        ST_LOCKOUT
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                miss_q, miss_d;
    logic [FC_W-1:0]     fail_q, fail_d;
    logic [LT_W-1:0]     lock_q, lock_d;
    logic [CODE_W-1:0]   code_q, code_d;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]     to_q, to_d;
`endif

    logic [DIGIT_W-1:0]  code_digit [CODE_LEN];
    logic                dig0_miss;
    logic                cur_miss;
    logic [FC_W-1:0]     fail_inc;

    // Stored code split into digits; digit 0 lives in the MSBs.
    always_comb begin
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            code_digit[i] = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        end
    end

    assign dig0_miss = (digit != code_digit[0]);
    assign cur_miss  = (digit != code_digit[idx_q]);
    assign fail_inc  = (fail_q == FAIL_MAX) ? FAIL_MAX : fail_q + 1'b1;

    // State register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            miss_q  <= 1'b0;
            fail_q  <= '0;
            lock_q  <= '0;
            code_q  <= DEFAULT_CODE;
`ifdef ENTRY_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            miss_q  <= miss_d;
            fail_q  <= fail_d;
            lock_q  <= lock_d;
            code_q  <= code_d;
`ifdef ENTRY_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // Next-state logic. Index and mismatch flag are cleared on every exit
    // from entry, so IDLE is always entered with them already at zero.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        fail_d  = fail_q;
        lock_d  = lock_q;
        code_d  = code_q;
`ifdef ENTRY_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (digit_valid) begin
`ifdef ENTRY_TIMEOUT_EN
                    to_d = TO_LOAD;
`endif
                    if (CODE_LEN == 1) begin
                        if (dig0_miss) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end
                    end else begin
                        state_d = ST_ENTRY;
                        idx_d   = IDX_W'(1);
                        miss_d  = dig0_miss;
                    end
                end
            end
            ST_ENTRY: begin
                if (digit_valid) begin
`ifdef ENTRY_TIMEOUT_EN
                    to_d = TO_LOAD;
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        miss_d = 1'b0;
                        if (miss_q || cur_miss) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        miss_d = miss_q | cur_miss;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (to_q == '0) begin
                    state_d = ST_ERROR;
                    idx_d   = '0;
                    miss_d  = 1'b0;
                end else begin
                    to_d = to_q - 1'b1;
                end
`endif
            end
            ST_OPEN: begin
                if (code_load) begin
                    code_d = code_in;
                end
                if (relock) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                fail_d = fail_inc;
                if (fail_inc == FAIL_MAX) begin
                    state_d = ST_LOCKOUT;
                    lock_d  = LOCK_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (lock_q == '0) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        led_right  = (state_q == ST_OPEN);
        led_wrong  = (state_q == ST_ERROR);
        buzzer     = (state_q == ST_LOCKOUT);
        fail_count = fail_q;
    end

endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
Parametrised digital-locker controller. Accepts a keyed sequence of CODE_LEN digits, each DIGIT_W bits wide, and compares it against a programmable stored code. It drives the unlock and error LEDs, counts consecutive failed attempts, and enters a timed buzzer lockout after MAX_FAIL failures. It sits between the debounced button/keypad front end and the door actuator/indicator outputs.

Parameters:
DIGIT_W, 2, bits per entered digit
CODE_LEN, 4, digits per code (>=1)
DEFAULT_CODE, 8'b00110011, code loaded at reset; width CODE_LEN*DIGIT_W; digit 0 = MSBs
MAX_FAIL, 3, consecutive failures that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, clock cycles spent in lockout (>=1)
TIMEOUT_CYCLES, 64, idle cycles allowed between digits (used only with ENTRY_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
digit_valid  in  1  one-cycle strobe; digit is sampled this cycle
digit  in  DIGIT_W  entered digit value
relock  in  1  pulse; returns OPEN to IDLE
code_load  in  1  pulse; latch code_in as new stored code (honoured in OPEN only)
code_in  in  CODE_LEN*DIGIT_W  new code, digit 0 in MSBs
led_right  out  1  high while in OPEN
led_wrong  out  1  high while in ERROR
buzzer  out  1  high while in LOCKOUT
fail_count  out  clog2(MAX_FAIL+1)  consecutive failed attempts

Behaviour:
- Reset (clear_n=0, async): state=IDLE, digit index=0, mismatch flag=0, fail_count=0, lockout timer=0, stored code=DEFAULT_CODE. All LED and buzzer outputs are 0.
- Outputs are Moore outputs decoded from the state register. They change in the cycle after the causing input is sampled.
- States: IDLE, ENTRY, OPEN, ERROR, LOCKOUT.
- IDLE: digit_valid compares digit with stored digit 0.
  - Mismatch sets the flag. Index becomes 1.
  - If CODE_LEN=1, go directly to the evaluation step. Otherwise go to ENTRY.
- ENTRY: each digit_valid compares digit with stored digit[index]. A mismatch sets the sticky flag.
  - When the CODE_LEN-th digit is sampled, evaluate: flag clear (including this digit) -> OPEN; otherwise -> ERROR.
  - Cycles without digit_valid hold state.
- A wrong code is reported only after all CODE_LEN digits are entered, never at the mismatching position.
- OPEN: led_right=1. fail_count is cleared on entry. digit_valid is ignored.
  - relock -> IDLE next cycle.
  - code_load updates the stored code next edge.
  - code_load and relock in the same cycle: both take effect (new code stored, go to IDLE).
- ERROR: lasts exactly one cycle; led_wrong=1. fail_count increments, saturating at MAX_FAIL.
  - If the incremented value equals MAX_FAIL -> LOCKOUT, timer loaded with LOCKOUT_CYCLES-1. Otherwise -> IDLE.
  - digit_valid during ERROR is ignored.
- LOCKOUT: buzzer=1 for exactly LOCKOUT_CYCLES cycles. All inputs are ignored.
  - Timer decrements each cycle. At 0 -> IDLE, fail_count cleared.
- code_load outside OPEN is ignored. relock outside OPEN is ignored.
- Index and flag clear whenever the FSM enters IDLE.
- A digit_valid on the same edge as the IDLE transition is not captured.
- Reset asserted mid-entry, mid-lockout or in OPEN aborts immediately to the reset values. The stored code reverts to DEFAULT_CODE.
- Index width: clog2(CODE_LEN) (minimum 1). Index never exceeds CODE_LEN-1.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined: a timeout counter reloads on every digit_valid in IDLE or ENTRY.
  - In ENTRY, if TIMEOUT_CYCLES consecutive cycles pass without digit_valid, the FSM goes to ERROR and is treated as a failed attempt (fail_count increments, lockout rules apply).
  - The counter is inactive in IDLE, OPEN, ERROR and LOCKOUT.
- Undefined: no timer logic is present. ENTRY waits indefinitely.

Test Plan:
- Defaults, digits 0,3,0,3 on consecutive strobes -> led_right=1 the cycle after the 4th digit; fail_count=0. relock -> led_right=0 next cycle.
- Digits 0,3,1,3 -> no output change until after the 4th digit, then led_wrong=1 for exactly 1 cycle; fail_count=1; state IDLE.
- Three wrong 4-digit entries -> after the third, led_wrong pulses, then buzzer=1 for exactly 16 cycles. Digits 0,3,0,3 strobed during buzzer are ignored. After the buzzer, fail_count=0 and a correct entry opens.
- In OPEN, code_load with code_in=8'b11100100 -> relock. Digits 0,3,0,3 now fail; digits 3,2,1,0 open. Assert clear_n=0 -> code reverts and 0,3,0,3 opens again.
- Two wrong entries then a correct entry -> fail_count 1, 2, then 0 on OPEN. Assert clear_n mid-ENTRY after 2 digits -> all outputs 0, index 0, next 0,3,0,3 opens.
- With ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=64: digits 0,3 then 64 idle cycles -> led_wrong=1 for 1 cycle, fail_count=1. With the macro undefined: same stimulus, 200 idle cycles, then digits 0,3 -> led_right=1.
